// File: rtl/fixed_multiplier_pkg.sv
// Shared definitions for the fixed-point multiplier (operand format matches the divider).
package fixed_multiplier_pkg;

  localparam int unsigned DEF_W = 10;
  localparam int unsigned DEF_F = 6;

  // Saturated result returned on overflow at the default width
  localparam logic [DEF_W-1:0] SAT_VAL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/fixed_multiplier_if.sv
// Operand/result handshake bundle between a requester and the multiplier.
interface fixed_multiplier_if
  import fixed_multiplier_pkg::*;
#(
  parameter int unsigned W = DEF_W
) ();

  logic         start;
  logic [W-1:0] A_in;
  logic [W-1:0] B_in;
  logic [W-1:0] P_out;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, A_in, B_in,
    input  P_out, ovf, busy, done
  );

  modport slave (
    input  start, A_in, B_in,
    output P_out, ovf, busy, done
  );

endinterface

// File: rtl/fixed_multiplier_ctrl.sv
// Sequencer for the shift-add multiplier: FSM plus iteration counter.
module mult_ctrl
  import fixed_multiplier_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ld_c,
  output logic shift_c,
  output logic last_c,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(W);

  mult_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eqlast;

  assign eqlast = (cnt_q == CNT_W'(W - 1));

  // Next-state, counter and strobe decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_c    = 1'b0;
    shift_c = 1'b0;
    last_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ld_c    = 1'b1;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        shift_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (eqlast) begin
          last_c  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, counter and status flops; status tracks the state register exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/fixed_multiplier.sv
// Radix-2 shift-add unsigned UQ(W-F).F multiplier with truncation and saturation.
module fixed_multiplier
  import fixed_multiplier_pkg::*;
#(
  parameter int unsigned W = DEF_W,
  parameter int unsigned F = DEF_F
) (
  input  logic                 clk,
  input  logic                 rst,
  fixed_multiplier_if.slave    bus
);

  logic         ld_c, shift_c, last_c;
  logic         busy, done;

  logic [W-1:0] ra_q, ra_d;
  logic [W:0]   acc_q, acc_d;
  logic [W-1:0] rq_q, rq_d;
  logic [W-1:0] p_out_q, p_out_d;
  logic         ovf_q, ovf_d;
  logic [W:0]   sum;

  mult_ctrl #(.W(W)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.start),
    .ld_c    (ld_c),
    .shift_c (shift_c),
    .last_c  (last_c),
    .busy    (busy),
    .done    (done)
  );

  // Operand load, conditional add / shift step, and result capture on the final step
  always_comb begin
    ra_d    = ra_q;
    acc_d   = acc_q;
    rq_d    = rq_q;
    p_out_d = p_out_q;
    ovf_d   = ovf_q;
    sum     = rq_q[0] ? ({1'b0, acc_q[W-1:0]} + {1'b0, ra_q}) : acc_q;
    if (ld_c) begin
      ra_d  = bus.A_in;
      rq_d  = bus.B_in;
      acc_d = '0;
    end else if (shift_c) begin
      acc_d = {1'b0, sum[W:1]};
      rq_d  = {sum[0], rq_q[W-1:1]};
      if (last_c) begin
        // Full product is {acc[W-1:0], rq}; integer overflow bits live in acc[W-1:F]
        ovf_d   = |acc_d[W-1:F];
        p_out_d = ovf_d ? '1 : {acc_d[F-1:0], rq_d[W-1:F]};
      end
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q    <= '0;
      acc_q   <= '0;
      rq_q    <= '0;
      p_out_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ra_q    <= ra_d;
      acc_q   <= acc_d;
      rq_q    <= rq_d;
      p_out_q <= p_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.P_out = p_out_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = busy;
  assign bus.done  = done;

endmodule

// File: tb/tb_fixed_multiplier.sv
// Self-checking bench for fixed_multiplier: directed table, protocol/reset sequences, random ops.
module tb_fixed_multiplier;
  import fixed_multiplier_pkg::*;

  localparam int unsigned W = DEF_W;
  localparam int unsigned F = DEF_F;

  logic clk = 1'b0;
  logic rst;

  int n_vec = 0;
  int n_bad = 0;

  fixed_multiplier_if #(.W(W)) bus ();

  fixed_multiplier #(.W(W), .F(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic         o;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: real-valued product floor(A*B / 2^F), saturated if it does not fit W bits
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] p, output logic o);
    longint unsigned prod;
    longint unsigned q;
    prod = longint'(a) * longint'(b);
    q    = prod / (64'd1 << F);
    o    = (q >= (64'd1 << W));
    p    = o ? SAT_VAL : W'(q);
  endfunction

  // Issue one op from a post-edge point; observe 20 cycles after the accepting edge
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] p, output logic o,
                        output int done_at, output int done_n, output int busy_n);
    p = '0; o = 1'b0; done_at = -1; done_n = 0; busy_n = 0;
    bus.start = 1'b1;
    bus.A_in  = a;
    bus.B_in  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A_in  = ~a;
    bus.B_in  = ~b;
    for (int c = 1; c <= 20; c++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          p = bus.P_out;
          o = bus.ovf;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [W-1:0] p, ep, ra, rb;
    logic         o, eo;
    int           done_at, done_n, busy_n;
    int           second_at;
    logic [W-1:0] p2;
    logic         o2;
    logic         idle_seen;

    tbl[0] = '{a: 10'h040, b: 10'h040, p: 10'h040, o: 1'b0};
    tbl[1] = '{a: 10'h0A0, b: 10'h0D0, p: 10'h208, o: 1'b0};
    tbl[2] = '{a: 10'h100, b: 10'h100, p: 10'h3FF, o: 1'b1};
    tbl[3] = '{a: 10'h3FF, b: 10'h3FF, p: 10'h3FF, o: 1'b1};
    tbl[4] = '{a: 10'h2AB, b: 10'h000, p: 10'h000, o: 1'b0};
    tbl[5] = '{a: 10'h000, b: 10'h3FF, p: 10'h000, o: 1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.A_in  = '0;
    bus.B_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_p_out", int'(bus.P_out), 0);
    chk("reset_ovf",   int'(bus.ovf),   0);
    chk("reset_busy",  int'(bus.busy),  0);
    chk("reset_done",  int'(bus.done),  0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, p, o, done_at, done_n, busy_n);
      chk($sformatf("tbl%0d_p", i),       int'(p),       int'(tbl[i].p));
      chk($sformatf("tbl%0d_ovf", i),     int'(o),       int'(tbl[i].o));
      chk($sformatf("tbl%0d_done_at", i), done_at,       11);
      chk($sformatf("tbl%0d_done_n", i),  done_n,        1);
      chk($sformatf("tbl%0d_busy_n", i),  busy_n,        11);
      chk($sformatf("tbl%0d_held", i),    int'(bus.P_out), int'(tbl[i].p));
    end

    // Start held high, operands changed after the accepting edge
    bus.start = 1'b1;
    bus.A_in  = 10'h040;
    bus.B_in  = 10'h040;
    @(posedge clk); #1;
    bus.A_in  = 10'h3FF;
    bus.B_in  = 10'h3FF;
    done_n = 0; done_at = -1; second_at = -1; idle_seen = 1'b0;
    p = '0; o = 1'b0; p2 = '0; o2 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 12 && !bus.busy) idle_seen = 1'b1;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c; p = bus.P_out; o = bus.ovf;
        end else if (second_at < 0) begin
          second_at = c; p2 = bus.P_out; o2 = bus.ovf;
        end
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("proto_first_at",  done_at,     11);
    chk("proto_first_p",   int'(p),     'h040);
    chk("proto_first_ovf", int'(o),     0);
    chk("proto_idle_gap",  int'(idle_seen), 1);
    chk("proto_done_n",    done_n,      2);
    chk("proto_second_p",  int'(p2),    'h3FF);
    chk("proto_second_ovf", int'(o2),   1);
    repeat (15) @(posedge clk);
    #1;

    // Reset in the middle of CALC; P_out currently holds the saturated result
    bus.start = 1'b1;
    bus.A_in  = 10'h3FF;
    bus.B_in  = 10'h3FF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy",  int'(bus.busy),  0);
    chk("rst_p_out", int'(bus.P_out), 0);
    chk("rst_ovf",   int'(bus.ovf),   0);
    done_n = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.done) done_n++;
      @(posedge clk); #1;
    end
    chk("rst_no_done", done_n, 0);
    run_op(10'h040, 10'h080, p, o, done_at, done_n, busy_n);
    chk("post_rst_p",    int'(p), 'h080);
    chk("post_rst_ovf",  int'(o), 0);
    chk("post_rst_done", done_n,  1);

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      if (i % 4 == 0) rb = W'($urandom_range(0, 'h0FF));
      model(ra, rb, ep, eo);
      run_op(ra, rb, p, o, done_at, done_n, busy_n);
      chk($sformatf("rnd%0d_p(%0h*%0h)", i, ra, rb), int'(p), int'(ep));
      chk($sformatf("rnd%0d_ovf", i),                int'(o), int'(eo));
      chk($sformatf("rnd%0d_done_at", i),            done_at, 11);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
